rsp_s2_prep_wide_add: RTL

- Multi-cycle wide unsigned adder in the rsp_s2_prep stage.
- Splits two NUM_WORDS*DATA_WIDTH operands into DATA_WIDTH words and adds them LSW-first, one word per cycle, through a single carry-in/carry-out adder slice.
- The carry is registered between words.
- Sits directly upstream of downstream s2 prep consumers: valid/ready in, valid/ready out.

---
 rtl/rsp_s2_prep_pkg.sv | 19 +
 rtl/rsp_s2_prep_add_u.sv | 14 +
 rtl/rsp_s2_prep_wide_add.sv | 118 +++++++++++
 3 files changed

// File: rtl/rsp_s2_prep_pkg.sv
// Shared types and constants for the rsp_s2_prep wide adder.
// The optional overflow output is enabled by defining RSP_S2_PREP_WIDE_ADD_OVF_EN.
package rsp_s2_prep_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_NUM_WORDS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Word-index counter width; a single-word operand still needs one bit.
  function automatic int unsigned idx_width(input int unsigned num_words);
    return (num_words <= 1) ? 1 : $clog2(num_words);
  endfunction

endpackage

// File: rtl/rsp_s2_prep_add_u.sv
// Carry-in/carry-out adder slice used by the s2 prep stage.
module rsp_s2_prep_add_u #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_cin,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + (DATA_WIDTH + 1)'(i_cin);

endmodule

// File: rtl/rsp_s2_prep_wide_add.sv
// Multi-cycle wide unsigned adder: one DATA_WIDTH word per cycle, LSW first.
// Defining RSP_S2_PREP_WIDE_ADD_OVF_EN adds the signed-overflow output m_ovf.
module rsp_s2_prep_wide_add
  import rsp_s2_prep_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] s_a,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] s_b,
  input  logic                            s_cin,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] m_sum,
  output logic                            m_cout
`ifdef RSP_S2_PREP_WIDE_ADD_OVF_EN
  ,
  output logic                            m_ovf
`endif
);

  localparam int unsigned IW = idx_width(NUM_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  state_e                               r_state;
  logic [IW-1:0]                        r_idx;
  logic                                 r_carry;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] r_a;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] r_b;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] r_sum;
  logic                                 r_cout;

  logic [DATA_WIDTH-1:0] w_a_word;
  logic [DATA_WIDTH-1:0] w_b_word;
  logic [DATA_WIDTH-1:0] w_sum_word;
  logic                  w_cout;

  assign w_a_word = r_a[r_idx];
  assign w_b_word = r_b[r_idx];

  rsp_s2_prep_add_u #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_add (
    .i_a   (w_a_word),
    .i_b   (w_b_word),
    .i_cin (r_carry),
    .o_sum (w_sum_word),
    .o_cout(w_cout)
  );

`ifdef RSP_S2_PREP_WIDE_ADD_OVF_EN
  // Carry-in XOR carry-out of the MSB, expressed through operand/result sign bits.
  logic w_ovf;
  logic r_ovf;
  assign w_ovf = (w_a_word[DATA_WIDTH-1] == w_b_word[DATA_WIDTH-1]) &&
                 (w_sum_word[DATA_WIDTH-1] != w_a_word[DATA_WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == CALC) && (r_idx == LAST_IDX)) begin
      r_ovf <= w_ovf;
    end
  end

  assign m_ovf = r_ovf;
`endif

  // Control FSM with word counter, carry, operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_valid) begin
            r_a     <= s_a;
            r_b     <= s_b;
            r_carry <= s_cin;
            r_idx   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_sum[r_idx] <= w_sum_word;
          r_carry      <= w_cout;
          r_idx        <= r_idx + IW'(1);
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_cout;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (m_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready = (r_state == IDLE);
  assign m_valid = (r_state == DONE);
  assign m_sum   = r_sum;
  assign m_cout  = r_cout;

endmodule
